// File: rtl/cnl_result_checker_pkg.sv
// Shared FSM state type and stall-LFSR constants for the result checker.
package cnl_result_checker_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0, 2, 3, 5.
  localparam logic [15:0] LfsrTapMask     = 16'h002D;
  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

endpackage

// File: rtl/cnl_lfsr_stall.sv
// Pseudo-random stall source: 16-bit LFSR, stall whenever the two low bits are zero.
module cnl_lfsr_stall
  import cnl_result_checker_pkg::*;
(
  input  logic        clk_core,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic        stall
);

  logic [15:0] lfsr_q, lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = ^(lfsr_q & LfsrTapMask);
    lfsr_d   = lfsr_q;
    if (load) begin
      // An all-zero seed would lock the LFSR up.
      lfsr_d = (seed == 16'h0000) ? LfsrDefaultSeed : seed;
    end else if (advance) begin
      lfsr_d = {feedback, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LfsrDefaultSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);

endmodule

// File: rtl/cnl_result_checker.sv
// Compares a result stream against a golden stream over a rows x cols x kernels volume.
// Define CNL_RESULT_STALL_EN to insert LFSR-driven pseudo-random stalls on the handshakes.
module cnl_result_checker
  import cnl_result_checker_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 16,
  parameter int unsigned C_NUM_LANES  = 1,
  parameter int unsigned C_DIM_WIDTH  = 10,
  parameter int unsigned C_ERR_WIDTH  = 16
) (
  input  logic                                clk_core,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [C_DIM_WIDTH-1:0]              num_output_rows_cfg,
  input  logic [C_DIM_WIDTH-1:0]              num_output_cols_cfg,
  input  logic [C_DIM_WIDTH-1:0]              num_kernel_cfg,
  input  logic                                result_valid,
  output logic                                result_accept,
  input  logic [C_NUM_LANES*C_DATA_WIDTH-1:0] result_data,
  input  logic                                exp_valid,
  output logic                                exp_ready,
  input  logic [C_NUM_LANES*C_DATA_WIDTH-1:0] exp_data,
  output logic [C_DIM_WIDTH-1:0]              output_row,
  output logic [C_DIM_WIDTH-1:0]              output_col,
  output logic [C_DIM_WIDTH-1:0]              output_depth,
  output logic                                mismatch_valid,
  output logic [C_ERR_WIDTH-1:0]              mismatch_count,
  output logic [C_DIM_WIDTH-1:0]              first_err_row,
  output logic [C_DIM_WIDTH-1:0]              first_err_col,
  output logic [C_DIM_WIDTH-1:0]              first_err_depth,
  output logic                                busy,
  output logic                                done,
  input  logic                                done_ack,
  input  logic [15:0]                         stall_seed
);

  localparam int unsigned PosWidth = C_DIM_WIDTH + 1;

  state_e                 state_q, state_d;
  logic [C_DIM_WIDTH-1:0] rows_q, cols_q, kern_q;
  logic [C_DIM_WIDTH-1:0] row_q, col_q, depth_q;
  logic [C_DIM_WIDTH-1:0] err_row_q, err_col_q, err_depth_q;
  logic [C_ERR_WIDTH-1:0] count_q;
  logic                   mis_valid_q, err_seen_q, drain_q;

  logic                   stall, cfg_accept, cfg_zero, run_active, xfer;
  logic                   beat_mis, depth_wrap, col_last, row_last, last_beat;
  logic [PosWidth-1:0]    depth_step, lane_pos;

`ifdef CNL_RESULT_STALL_EN
  cnl_lfsr_stall u_stall (
    .clk_core (clk_core),
    .rst      (rst),
    .load     (cfg_accept),
    .seed     (stall_seed),
    .advance  (state_q == StRun),
    .stall    (stall)
  );
`else
  logic unused_stall_seed;
  assign unused_stall_seed = ^stall_seed;
  assign stall             = 1'b0;
`endif

  assign cfg_accept = (state_q == StIdle) && cfg_valid;
  assign cfg_zero   = (num_output_rows_cfg == '0) || (num_output_cols_cfg == '0) ||
                      (num_kernel_cfg == '0);
  // Once the last beat is taken, hold off further transfers until DONE.
  assign run_active    = (state_q == StRun) && !drain_q;
  assign result_accept = run_active && exp_valid && !stall;
  assign exp_ready     = run_active && result_valid && !stall;
  assign xfer          = run_active && result_valid && exp_valid && !stall;

  assign depth_step = {1'b0, depth_q} + PosWidth'(C_NUM_LANES);
  assign depth_wrap = depth_step >= {1'b0, kern_q};
  assign col_last   = (col_q == cols_q - 1'b1);
  assign row_last   = (row_q == rows_q - 1'b1);
  assign last_beat  = depth_wrap && col_last && row_last;

  // Lanes past the kernel count in the final depth group carry no real data.
  always_comb begin
    beat_mis = 1'b0;
    lane_pos = '0;
    for (int unsigned l = 0; l < C_NUM_LANES; l++) begin
      lane_pos = {1'b0, depth_q} + PosWidth'(l);
      if ((lane_pos < {1'b0, kern_q}) &&
          (result_data[l*C_DATA_WIDTH +: C_DATA_WIDTH] !=
           exp_data[l*C_DATA_WIDTH +: C_DATA_WIDTH])) begin
        beat_mis = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cfg_valid) state_d = cfg_zero ? StDone : StRun;
      StRun:   if (drain_q) state_d = StDone;
      StDone:  if (done_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: cfg_ready = 1'b1;
      StRun:  busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      rows_q      <= '0;
      cols_q      <= '0;
      kern_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      depth_q     <= '0;
      err_row_q   <= '0;
      err_col_q   <= '0;
      err_depth_q <= '0;
      count_q     <= '0;
      mis_valid_q <= 1'b0;
      err_seen_q  <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      mis_valid_q <= xfer && beat_mis;
      if (cfg_accept) begin
        rows_q      <= num_output_rows_cfg;
        cols_q      <= num_output_cols_cfg;
        kern_q      <= num_kernel_cfg;
        row_q       <= '0;
        col_q       <= '0;
        depth_q     <= '0;
        err_row_q   <= '0;
        err_col_q   <= '0;
        err_depth_q <= '0;
        count_q     <= '0;
        err_seen_q  <= 1'b0;
        drain_q     <= 1'b0;
      end else if (xfer) begin
        if (last_beat) begin
          drain_q <= 1'b1;
        end
        if (depth_wrap) begin
          depth_q <= '0;
          if (col_last) begin
            col_q <= '0;
            row_q <= row_last ? '0 : row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end else begin
          depth_q <= depth_step[C_DIM_WIDTH-1:0];
        end
        if (beat_mis) begin
          if (count_q != '1) begin
            count_q <= count_q + 1'b1;
          end
          if (!err_seen_q) begin
            err_row_q   <= row_q;
            err_col_q   <= col_q;
            err_depth_q <= depth_q;
            err_seen_q  <= 1'b1;
          end
        end
      end
    end
  end

  assign output_row      = row_q;
  assign output_col      = col_q;
  assign output_depth    = depth_q;
  assign mismatch_valid  = mis_valid_q;
  assign mismatch_count  = count_q;
  assign first_err_row   = err_row_q;
  assign first_err_col   = err_col_q;
  assign first_err_depth = err_depth_q;

endmodule

// File: tb/tb_cnl_result_checker.sv
// Scoreboard bench: drivers queue the expected position/mismatch of every beat,
// monitors pop on each observed transfer and check the registered mismatch pulse.
module tb_cnl_result_checker;

  typedef struct {
    int row;
    int col;
    int depth;
    bit mis;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Single-lane instance
  logic        c1_cv, c1_cr, c1_rv, c1_acc, c1_ev, c1_erdy, c1_mv, c1_busy, c1_done, c1_ack;
  logic [9:0]  c1_rows, c1_cols, c1_kern, c1_row, c1_col, c1_dep, c1_frow, c1_fcol, c1_fdep;
  logic [15:0] c1_rd, c1_ed, c1_cnt, c1_seed;
  // Four-lane instance
  logic        c4_cv, c4_cr, c4_rv, c4_acc, c4_ev, c4_erdy, c4_mv, c4_busy, c4_done, c4_ack;
  logic [9:0]  c4_rows, c4_cols, c4_kern, c4_row, c4_col, c4_dep, c4_frow, c4_fcol, c4_fdep;
  logic [63:0] c4_rd, c4_ed;
  logic [15:0] c4_cnt, c4_seed;

  cnl_result_checker u_dut1 (
    .clk_core(clk), .rst(rst_n), .cfg_valid(c1_cv), .cfg_ready(c1_cr),
    .num_output_rows_cfg(c1_rows), .num_output_cols_cfg(c1_cols), .num_kernel_cfg(c1_kern),
    .result_valid(c1_rv), .result_accept(c1_acc), .result_data(c1_rd),
    .exp_valid(c1_ev), .exp_ready(c1_erdy), .exp_data(c1_ed),
    .output_row(c1_row), .output_col(c1_col), .output_depth(c1_dep),
    .mismatch_valid(c1_mv), .mismatch_count(c1_cnt),
    .first_err_row(c1_frow), .first_err_col(c1_fcol), .first_err_depth(c1_fdep),
    .busy(c1_busy), .done(c1_done), .done_ack(c1_ack), .stall_seed(c1_seed)
  );

  cnl_result_checker #(.C_NUM_LANES(4)) u_dut4 (
    .clk_core(clk), .rst(rst_n), .cfg_valid(c4_cv), .cfg_ready(c4_cr),
    .num_output_rows_cfg(c4_rows), .num_output_cols_cfg(c4_cols), .num_kernel_cfg(c4_kern),
    .result_valid(c4_rv), .result_accept(c4_acc), .result_data(c4_rd),
    .exp_valid(c4_ev), .exp_ready(c4_erdy), .exp_data(c4_ed),
    .output_row(c4_row), .output_col(c4_col), .output_depth(c4_dep),
    .mismatch_valid(c4_mv), .mismatch_count(c4_cnt),
    .first_err_row(c4_frow), .first_err_col(c4_fcol), .first_err_depth(c4_fdep),
    .busy(c4_busy), .done(c4_done), .done_ack(c4_ack), .stall_seed(c4_seed)
  );

  beat_t q1[$];
  beat_t q4[$];
  bit    pend1, pend1_mis, pend4, pend4_mis;
  int    pulses1 = 0;
  int    pulses4 = 0;
  int    stalls1 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic no_beat(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got transfer, expected none queued", name);
  endtask

  // Monitors sample mid-cycle; drivers change inputs just after the rising edge.
  always @(negedge clk) begin
    beat_t b;
    if (c1_mv) pulses1++;
    if (pend1) chk("c1_mismatch_valid", c1_mv, pend1_mis);
    else if (c1_mv) chk("c1_spurious_mismatch_valid", c1_mv, 0);
    pend1 = 0;
    if (c1_rv && c1_ev && c1_acc && c1_erdy) begin
      if (q1.size() == 0) begin
        no_beat("c1_unexpected_transfer");
      end else begin
        b = q1.pop_front();
        chk("c1_row", c1_row, b.row);
        chk("c1_col", c1_col, b.col);
        chk("c1_depth", c1_dep, b.depth);
        pend1     = 1;
        pend1_mis = b.mis;
      end
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (c4_mv) pulses4++;
    if (pend4) chk("c4_mismatch_valid", c4_mv, pend4_mis);
    else if (c4_mv) chk("c4_spurious_mismatch_valid", c4_mv, 0);
    pend4 = 0;
    if (c4_rv && c4_ev && c4_acc && c4_erdy) begin
      if (q4.size() == 0) begin
        no_beat("c4_unexpected_transfer");
      end else begin
        b = q4.pop_front();
        chk("c4_row", c4_row, b.row);
        chk("c4_col", c4_col, b.col);
        chk("c4_depth", c4_dep, b.depth);
        pend4     = 1;
        pend4_mis = b.mis;
      end
    end
  end

  // All driver tasks start just after a rising edge.
  task automatic cfg1(input int rows, input int cols, input int kern, input logic [15:0] seed);
    chk("c1_cfg_ready_before_cfg", c1_cr, 1);
    c1_rows = 10'(rows);
    c1_cols = 10'(cols);
    c1_kern = 10'(kern);
    c1_seed = seed;
    c1_cv   = 1;
    @(posedge clk); #1;
    c1_cv   = 0;
  endtask

  task automatic beat1(input logic [15:0] r, input logic [15:0] e);
    int n = 0;
    c1_rv = 1;
    c1_ev = 1;
    c1_rd = r;
    c1_ed = e;
    @(negedge clk);
    while (!(c1_acc && c1_erdy)) begin
      stalls1++;
      n++;
      if (n > 200) begin
        chk("c1_beat_timeout", c1_acc, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic run1(input int rows, input int cols, input int kern, input int bad,
                      input int limit);
    int          idx = 0;
    logic [15:0] d;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        for (int k = 0; k < kern; k++) begin
          if (idx < limit) begin
            d = 16'(r * 256 + c * 16 + k) ^ 16'hA5C3;
            q1.push_back('{row: r, col: c, depth: k, mis: (idx == bad)});
            beat1((idx == bad) ? (d ^ 16'h0100) : d, d);
          end
          idx++;
        end
      end
    end
    c1_rv = 0;
    c1_ev = 0;
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (!c1_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, c1_done, 1);
    chk({tag, "_queue_drained"}, q1.size(), 0);
  endtask

  task automatic ack1(input string tag);
    @(posedge clk); #1;
    c1_ack = 1;
    @(posedge clk); #1;
    c1_ack = 0;
    @(negedge clk);
    chk({tag, "_idle_cfg_ready"}, c1_cr, 1);
    chk({tag, "_idle_done"}, c1_done, 0);
    chk({tag, "_idle_busy"}, c1_busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic beat4(input logic [63:0] r, input logic [63:0] e, input int depth,
                       input bit mis);
    int n = 0;
    q4.push_back('{row: 0, col: 0, depth: depth, mis: mis});
    c4_rv = 1;
    c4_ev = 1;
    c4_rd = r;
    c4_ed = e;
    @(negedge clk);
    while (!(c4_acc && c4_erdy)) begin
      n++;
      if (n > 200) begin
        chk("c4_beat_timeout", c4_acc, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    c4_rv = 0;
    c4_ev = 0;
  endtask

  task automatic volume4(input logic [63:0] second_result, input bit mis, input string tag);
    int n = 0;
    chk({tag, "_cfg_ready"}, c4_cr, 1);
    c4_rows = 10'd1;
    c4_cols = 10'd1;
    c4_kern = 10'd6;
    c4_seed = 16'h1234;
    c4_cv   = 1;
    @(posedge clk); #1;
    c4_cv   = 0;
    beat4(64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 0, 0);
    beat4(second_result, 64'h0008_0007_0006_0005, 4, mis);
    while (!c4_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, c4_done, 1);
    chk({tag, "_count"}, c4_cnt, mis ? 1 : 0);
    chk({tag, "_queue_drained"}, q4.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    {c1_cv, c1_rv, c1_ev, c1_ack, c4_cv, c4_rv, c4_ev, c4_ack} = '0;
    {c1_rows, c1_cols, c1_kern, c4_rows, c4_cols, c4_kern} = '0;
    {c1_rd, c1_ed, c1_seed, c4_seed} = '0;
    {c4_rd, c4_ed} = '0;

    // Reset values
    @(negedge clk);
    chk("rst_cfg_ready", c1_cr, 1);
    chk("rst_busy", c1_busy, 0);
    chk("rst_done", c1_done, 0);
    chk("rst_mismatch_valid", c1_mv, 0);
    chk("rst_count", c1_cnt, 0);
    chk("rst_position", {c1_row, c1_col, c1_dep}, 0);
    chk("rst_first_err", {c1_frow, c1_fcol, c1_fdep}, 0);
    chk("rst_handshakes", {c1_acc, c1_erdy}, 0);
    chk("rst_c4_cfg_ready", c4_cr, 1);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // 2x2x3 clean volume, with DONE timing relative to the last compare
    cfg1(2, 2, 3, 16'h1234);
    chk("t1_busy_in_run", c1_busy, 1);
    run1(2, 2, 3, -1, 12);
    @(negedge clk);
    chk("t1_done_not_early", c1_done, 0);
    @(negedge clk);
    chk("t1_done_after_compare", c1_done, 1);
    wait_done1("t1");
    chk("t1_count", c1_cnt, 0);
    chk("t1_pulses", pulses1, 0);
    chk("t1_no_accept_in_done", c1_acc, 0);
    ack1("t1");

    // Beat 5 corrupted
    pulses1 = 0;
    cfg1(2, 2, 3, 16'h1234);
    run1(2, 2, 3, 5, 12);
    wait_done1("t2");
    chk("t2_count", c1_cnt, 1);
    chk("t2_pulses", pulses1, 1);
    chk("t2_first_err_row", c1_frow, 0);
    chk("t2_first_err_col", c1_fcol, 1);
    chk("t2_first_err_depth", c1_fdep, 2);
    ack1("t2");

    // Golden stream withheld for 10 cycles
    begin
      bit acc_seen = 0;
      cfg1(2, 2, 3, 16'h1234);
      c1_rv = 1;
      c1_ev = 0;
      c1_rd = 16'h7777;
      repeat (10) begin
        @(negedge clk);
        if (c1_acc) acc_seen = 1;
      end
      chk("t3_no_accept_without_exp", acc_seen, 0);
      chk("t3_position_held", {c1_row, c1_col, c1_dep}, 0);
      @(posedge clk); #1;
      run1(2, 2, 3, -1, 12);
      wait_done1("t3");
      chk("t3_count", c1_cnt, 0);
      ack1("t3");
    end

    // Zero column count goes straight to DONE
    cfg1(2, 0, 3, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    chk("t4_done", c1_done, 1);
    chk("t4_busy", c1_busy, 1);
    chk("t4_count", c1_cnt, 0);
    ack1("t4");

    // Reset after 5 beats, then a fresh stalled run
    cfg1(2, 2, 3, 16'h1234);
    run1(2, 2, 3, -1, 5);
    rst_n = 0;
    #1;
    chk("t5_rst_position", {c1_row, c1_col, c1_dep}, 0);
    chk("t5_rst_cfg_ready", c1_cr, 1);
    chk("t5_rst_busy", c1_busy, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    pulses1 = 0;
    stalls1 = 0;
    cfg1(2, 2, 3, 16'h0000);
    run1(2, 2, 3, -1, 12);
    wait_done1("t5");
    chk("t5_count", c1_cnt, 0);
    chk("t5_pulses", pulses1, 0);
`ifdef CNL_RESULT_STALL_EN
    chk("t5_stalls_observed", stalls1 > 0, 1);
`else
    chk("t5_no_stalls", stalls1, 0);
`endif
    ack1("t5");

    // Four lanes, six kernels: lanes 2-3 of beat 2 are padding
    volume4(64'hDEAD_BEEF_0006_0005, 0, "t6");
    chk("t6_pulses", pulses4, 0);
    @(posedge clk); #1;
    c4_ack = 1;
    @(posedge clk); #1;
    c4_ack = 0;
    @(posedge clk); #1;
    volume4(64'hDEAD_BEEF_0016_0005, 1, "t7");
    chk("t7_pulses", pulses4, 1);
    chk("t7_first_err_depth", c4_fdep, 4);
    chk("t7_first_err_pos", {c4_frow, c4_fcol}, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
